fcp6_cmd_queue: RTL and testbench

- Upstream command stage for the FCP6 link `top` (MASTER/SLAVE pair).
- Buffers host transaction requests (header + data) in a FIFO and issues them to the master one at a time:
  - presents `header_in`/`data_in`;
  - pulses `start` for one cycle;
  - tracks the master's `busy` to completion.
- Returns the master's `read_data` to the host through a response register with valid/ready handshake.
- Keeps at most one transaction in flight on the link.

---
 rtl/fcp6_pkg.sv | 21 ++
 rtl/fcp6_sync_fifo.sv | 64 ++++++
 rtl/fcp6_cmd_queue.sv | 132 +++++++++++++
 tb/tb_fcp6_cmd_queue.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcp6_pkg.sv
// Shared definitions for the FCP6 command queue: field widths, the queued
// command record and the issue FSM state encoding.
package fcp6_pkg;

    localparam int FCP6_HDR_W  = 8;
    localparam int FCP6_DATA_W = 8;
    localparam int FCP6_CMD_W  = FCP6_HDR_W + FCP6_DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } fcp6_q_state_t;

    typedef struct packed {
        logic [FCP6_HDR_W-1:0]  header;
        logic [FCP6_DATA_W-1:0] data;
    } fcp6_cmd_t;

endpackage

// File: rtl/fcp6_sync_fifo.sv
// Single-clock FIFO with occupancy count. Pushes while full and pops while
// empty are ignored, so callers may drive push/pop without pre-gating.
module fcp6_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_reg == FULL_LVL);
    assign empty   = (level_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign level   = level_reg;

    // Head is read combinationally; the consumer registers it on the pop edge.
    assign rdata = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + (AW + 1)'(1);
                2'b01:   level_reg <= level_reg - (AW + 1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/fcp6_cmd_queue.sv
// Host-side command queue for the FCP6 link master: buffers commands, issues
// them one at a time with a start pulse and returns the read data or a timeout.
import fcp6_pkg::*;

module fcp6_cmd_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [FCP6_HDR_W-1:0]     cmd_header,
    input  logic [FCP6_DATA_W-1:0]    cmd_data,
    output logic                      start,
    output logic [FCP6_HDR_W-1:0]     header_out,
    output logic [FCP6_DATA_W-1:0]    data_out,
    input  logic                      busy,
    input  logic [FCP6_DATA_W-1:0]    rd_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [FCP6_DATA_W-1:0]    rsp_data,
    output logic                      rsp_err,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    fcp6_q_state_t           state_reg;
    logic                    start_reg;
    logic [FCP6_HDR_W-1:0]   header_reg;
    logic [FCP6_DATA_W-1:0]  data_reg;
    logic                    rsp_valid_reg;
    logic [FCP6_DATA_W-1:0]  rsp_data_reg;
    logic                    rsp_err_reg;
    logic [TMR_W-1:0]        tmr_reg;

    fcp6_cmd_t               in_cmd;
    fcp6_cmd_t               head_cmd;
    logic [FCP6_CMD_W-1:0]   fifo_rdata;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    issue_go;

    assign in_cmd.header = cmd_header;
    assign in_cmd.data   = cmd_data;
    assign head_cmd      = fcp6_cmd_t'(fifo_rdata);

    // A pending response or a still-busy master holds off the next issue.
    assign issue_go = (state_reg == IDLE) && !fifo_empty && !rsp_valid_reg && !busy;

    fcp6_sync_fifo #(
        .WIDTH (FCP6_CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .wdata (in_cmd),
        .pop   (issue_go),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign cmd_ready  = !fifo_full;
    assign start      = start_reg;
    assign header_out = header_reg;
    assign data_out   = data_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_data   = rsp_data_reg;
    assign rsp_err    = rsp_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            start_reg     <= 1'b0;
            header_reg    <= '0;
            data_reg      <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
            tmr_reg       <= '0;
        end else begin
            start_reg <= 1'b0;
            if (rsp_valid_reg && rsp_ready) begin
                rsp_valid_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (issue_go) begin
                        header_reg <= head_cmd.header;
                        data_reg   <= head_cmd.data;
                        tmr_reg    <= '0;
                        start_reg  <= 1'b1;
                        state_reg  <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_reg <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (busy) begin
                        state_reg <= WAIT_DONE;
                    end else if (tmr_reg == TMR_LAST) begin
                        // Master never acknowledged: report an error response.
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b1;
                        rsp_data_reg  <= '0;
                        state_reg     <= IDLE;
                    end else begin
                        tmr_reg <= tmr_reg + TMR_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!busy) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b0;
                        rsp_data_reg  <= rd_data;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fcp6_cmd_queue.sv
// Directed bench for fcp6_cmd_queue: a transaction-level model is compared with
// the DUT every cycle, plus hand-computed expectations per scenario.
module tb_fcp6_cmd_queue;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_header = 8'h00;
    logic [7:0] cmd_data = 8'h00;
    logic       start;
    logic [7:0] header_out;
    logic [7:0] data_out;
    logic       busy = 1'b0;
    logic [7:0] rd_data = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [2:0] level;

    fcp6_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_header (cmd_header),
        .cmd_data   (cmd_data),
        .start      (start),
        .header_out (header_out),
        .data_out   (data_out),
        .busy       (busy),
        .rd_data    (rd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .level      (level)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // ---------------- master emulator: echoes data_out as read data -------
    bit master_en = 1'b1;
    int busy_len = 8;
    int m_phase = 0;
    int m_cnt = 0;

    always @(posedge clk) begin
        #2;
        if (rst) begin
            busy = 1'b0;
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (start && master_en) begin m_phase = 1; m_cnt = 1; end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        busy = 1'b1;
                        rd_data = data_out;
                        m_cnt = busy_len;
                        m_phase = 2;
                    end
                end
                default: begin
                    m_cnt--;
                    if (m_cnt == 0) begin busy = 1'b0; m_phase = 0; end
                end
            endcase
        end
    end

    // ---------------- transaction-level model ------------------------------
    logic [15:0] mq[$];
    longint cyc = 0;
    bit     m_inflight = 0;
    bit     m_busy_seen = 0;
    longint m_start_edge = 0;
    bit         e_start = 0;
    logic [7:0] e_hdr = 8'h00;
    logic [7:0] e_dat = 8'h00;
    bit         e_rv = 0;
    logic [7:0] e_rd = 8'h00;
    bit         e_re = 0;

    always @(posedge clk) begin
        bit acc;
        bit go;
        logic [15:0] c;
        cyc++;
        if (rst) begin
            mq.delete();
            m_inflight = 0; e_start = 0; e_hdr = 0; e_dat = 0;
            e_rv = 0; e_rd = 0; e_re = 0;
        end else begin
            acc = cmd_valid && (mq.size() < DEPTH);
            go = !m_inflight && (mq.size() > 0) && !e_rv && !busy;
            e_start = 0;
            if (e_rv && rsp_ready) e_rv = 0;
            if (go) begin
                c = mq.pop_front();
                e_hdr = c[15:8];
                e_dat = c[7:0];
                m_inflight = 1; m_busy_seen = 0; m_start_edge = cyc; e_start = 1;
            end else if (m_inflight && cyc > m_start_edge + 1) begin
                if (!m_busy_seen) begin
                    if (busy) m_busy_seen = 1;
                    else if (cyc - m_start_edge == TIMEOUT + 1) begin
                        e_rv = 1; e_re = 1; e_rd = 8'h00; m_inflight = 0;
                    end
                end else if (!busy) begin
                    e_rv = 1; e_re = 0; e_rd = rd_data; m_inflight = 0;
                end
            end
            if (acc) mq.push_back({cmd_header, cmd_data});
        end
    end

    // ---------------- per-cycle compare and monitors ------------------------
    int start_cnt = 0;
    int max_level = 0;
    logic [7:0] rsp_log[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_start", start, e_start);
            check("cyc_header_out", header_out, e_hdr);
            check("cyc_data_out", data_out, e_dat);
            check("cyc_rsp_valid", rsp_valid, e_rv);
            check("cyc_rsp_data", rsp_data, e_rd);
            check("cyc_rsp_err", rsp_err, e_re);
            check("cyc_level", level, mq.size());
            check("cyc_cmd_ready", cmd_ready, mq.size() < DEPTH);
        end
        if (start === 1'b1) start_cnt++;
        if (int'(level) > max_level) max_level = int'(level);
    end

    always @(posedge clk) begin
        if (!rst && rsp_valid && rsp_ready) rsp_log.push_back(rsp_data);
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic push(input logic [7:0] h, input logic [7:0] d, output bit stalled);
        int n = 0;
        stalled = !cmd_ready;
        cmd_valid = 1'b1; cmd_header = h; cmd_data = d;
        while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) check("push_timeout", 1, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        $display("push hdr=0x%02h data=0x%02h stalled=%0d", h, d, stalled);
    endtask

    // which: 0 = start, 1 = rsp_valid, 2 = busy
    task automatic wait_for(input int which, input string nm, input int lim, output int n);
        n = 0;
        while (n < lim) begin
            if (which == 0 && start) break;
            if (which == 1 && rsp_valid) break;
            if (which == 2 && busy) break;
            @(negedge clk);
            n++;
        end
        if (n >= lim) check(nm, 0, 1);
    endtask

    initial begin
        bit st;
        int n;
        int sc;
        logic [7:0] snap;

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_level", level, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_start", start, 0);
        check("rst_header_out", header_out, 8'h00);
        check("rst_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single write
        push(8'h67, 8'hA5, st);
        @(negedge clk);
        check("t1_start_high", start, 1);
        @(negedge clk);
        check("t1_start_one_cycle", start, 0);
        wait_for(2, "t1_busy_wait", 20, n);
        check("t1_header_while_busy", header_out, 8'h67);
        check("t1_data_while_busy", data_out, 8'hA5);
        wait_for(1, "t1_rsp_wait", 40, n);
        check("t1_rsp_data", rsp_data, 8'hA5);
        check("t1_rsp_err", rsp_err, 0);
        $display("rsp data=0x%02h err=%0d", rsp_data, rsp_err);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t1_rsp_cleared", rsp_valid, 0);

        // Fill and drain
        max_level = 0;
        push(8'h60, 8'h00, st);
        for (int i = 1; i <= 5; i++) begin
            push(8'(8'h60 + i), 8'(i), st);
            if (i == 5) check("t2_fifth_stalled", st, 1);
        end
        check("t2_max_level", max_level, 4);
        n = 0;
        while (rsp_log.size() < 7 && n < 500) begin @(negedge clk); n++; end
        check("t2_rsp_count", rsp_log.size(), 7);
        if (rsp_log.size() >= 7) begin
            check("t2_rsp0", rsp_log[0], 8'hA5);
            for (int i = 0; i <= 5; i++) check("t2_rsp_order", rsp_log[1 + i], i);
        end
        repeat (4) @(negedge clk);

        // Timeout
        rsp_ready = 1'b0;
        master_en = 1'b0;
        push(8'h70, 8'h11, st);
        push(8'h71, 8'h22, st);
        wait_for(0, "t3_start_wait", 20, n);
        n = 0;
        while (!rsp_valid && n < 60) begin @(negedge clk); n++; end
        check("t3_timeout_cycles", n, TIMEOUT + 1);
        check("t3_rsp_err", rsp_err, 1);
        check("t3_rsp_data", rsp_data, 8'h00);
        $display("rsp data=0x%02h err=%0d", rsp_data, rsp_err);
        sc = start_cnt;
        repeat (5) @(negedge clk);
        check("t3_no_issue_while_rsp", start_cnt, sc);
        check("t3_level_held", level, 1);
        master_en = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        wait_for(0, "t3_second_start", 10, n);
        wait_for(1, "t3_second_rsp", 40, n);
        check("t3_second_data", rsp_data, 8'h22);
        check("t3_second_err", rsp_err, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Response backpressure
        push(8'h80, 8'h33, st);
        push(8'h81, 8'h44, st);
        wait_for(1, "t4_rsp_wait", 40, n);
        snap = rsp_data;
        check("t4_first_data", snap, 8'h33);
        sc = start_cnt;
        repeat (20) begin
            @(negedge clk);
            check("t4_rsp_stable", rsp_data, 8'h33);
        end
        check("t4_no_second_start", start_cnt, sc);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_rsp_cleared", rsp_valid, 0);
        check("t4_start_not_yet", start, 0);
        @(negedge clk);
        check("t4_second_start", start, 1);
        wait_for(1, "t4_second_rsp", 40, n);
        check("t4_second_data", rsp_data, 8'h44);
        @(negedge clk);

        // Reset during WAIT_DONE
        busy_len = 30;
        push(8'h90, 8'h01, st);
        push(8'h91, 8'h02, st);
        push(8'h92, 8'h03, st);
        push(8'h93, 8'h04, st);
        wait_for(2, "t5_busy_wait", 20, n);
        repeat (2) @(negedge clk);
        check("t5_level_before", level, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_level", level, 0);
        check("t5_start", start, 0);
        check("t5_rsp_valid", rsp_valid, 0);
        check("t5_cmd_ready", cmd_ready, 1);
        sc = start_cnt;
        repeat (40) @(negedge clk);
        check("t5_no_start_after_rst", start_cnt, sc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
